mem_responder: RTL
==================

Name: mem_responder

Overview:
- Synthesizable memory-side responder for the processor/memory bus protocol: accepts BUS_LOAD/BUS_STORE commands, returns an acceptance tag in the same cycle, then returns a completion tag (plus load data) a fixed number of cycles later.
- Serves as the far end of the write-back/retire buffer store path and of the load path.
- Provides a tag-accurate memory model for integration benches, with injectable back-pressure to exercise initiator retry logic.

Parameters:
- NUM_TAGS, 15: number of allocatable tags; tags are 1..NUM_TAGS, 0 = `EMPTY_MEM_TAG`.
- LATENCY, 4: cycles from acceptance to completion. Legal range is 1..16.
- MEM_LINES, 256: number of 64-bit words in backing storage. Must be a power of 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- proc2mem_command  in  BUS_COMMAND  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2mem_addr  in  64  byte address; word index = addr[3 +: $clog2(MEM_LINES)], all other bits ignored
- proc2mem_data  in  64  store data
- accept_en  in  1  when 0, every command is rejected (back-pressure injection)
- mem2proc_response  out  MEM_TAG_T  combinational; tag allocated this cycle, 0 = rejected
- mem2proc_tag  out  MEM_TAG_T  registered; completing tag, 0 = none
- mem2proc_data  out  64  registered; load data for completing tag, 0 for stores and for idle cycles
- tags_in_use  out  $clog2(NUM_TAGS+1)  registered count of allocated tags (debug/verification)

Behaviour:
- Acceptance condition: command != BUS_NONE, accept_en = 1, reset = 0, and at least one tag is free.
  - If all hold: mem2proc_response = the lowest-numbered free tag, in the same cycle.
  - Otherwise mem2proc_response = 0 and nothing changes state.
- On the accept edge:
  - The tag is marked allocated.
  - BUS_STORE writes proc2mem_data into mem[idx].
  - BUS_LOAD snapshots mem[idx] into the pipeline, so any store accepted in an earlier cycle is visible.
  - At most one accept per cycle.
- Completion pipeline:
  - LATENCY-stage shift register of {valid, tag, data}; stage 0 is loaded on the accept edge.
  - mem2proc_tag/mem2proc_data are driven from the last stage, so a command accepted in cycle t completes in cycle t+LATENCY, exactly once.
  - Completions are strictly in acceptance order, one per cycle at most.
  - Idle stage outputs: tag 0, data 0.
- Tag free:
  - The completing tag is freed on the edge ending its completion cycle.
  - It is allocatable from the next cycle; a tag completing in cycle c is never re-issued in cycle c.
- Exhaustion: if NUM_TAGS < LATENCY, requests beyond NUM_TAGS outstanding get response 0 until a completion frees a tag.
- Commands are never queued internally; a rejected initiator must re-present the command.
- Simultaneous accept and completion in one cycle are independent. tags_in_use changes by +1, -1, or 0.
- Reset (asynchronous, any cycle):
  - Clears the free list (all tags free), all pipeline stages, the memory array (all 0) and tags_in_use.
  - mem2proc_tag = 0, mem2proc_data = 0; mem2proc_response is forced 0 while reset is high.
  - In-flight transactions are dropped and never complete.
- Width rules:
  - Tag arithmetic uses MEM_TAG_T (4 bits); NUM_TAGS <= 15.
  - Address upper bits beyond the index wrap silently (aliasing).

Decomposition:
- Shared package (sys_defs.vh): BUS_COMMAND, MEM_TAG_T and `EMPTY_MEM_TAG (existing).
- New in the package:
  - MEM_PIPE_ENTRY_T {valid, tag, data}.
  - EMPTY_MEM_PIPE_ENTRY constant.
- Sub-module tag_free_list:
  - NUM_TAGS-bit free vector with lowest-free priority encoder, allocate/free ports and in-use count.
  - The rest (pipeline, array) stays in mem_responder.

Test Plan:
- Reset: hold reset 2 cycles, then BUS_NONE → response 0, tag 0, data 0, tags_in_use 0.
- Store/load round trip:
  - STORE addr 0x40, data 0xDEADBEEF in cycle 0 → response 1; cycle 4: tag 1, data 0.
  - LOAD 0x40 in cycle 5 → response 1; cycle 9: tag 1, data 0xDEADBEEF.
- Back-to-back: STOREs in cycles 0-3 → responses 1,2,3,4; tags 1,2,3,4 in cycles 4-7; tags_in_use peaks at 4.
- Back-pressure: accept_en = 0 in cycle 0 with STORE → response 0 and no completion in cycle 4; retry in cycle 1 with accept_en = 1 → response 1, tag 1 in cycle 5.
- Exhaustion (NUM_TAGS = 2, LATENCY = 4): commands in cycles 0-5 → responses 1,2,0,0,0,1.
  - Tag 1 completes in cycle 4 and is re-issued in cycle 5, not 4.
- Reset mid-flight: STORE 0x8 = 0x55 accepted in cycle 0, reset pulsed in cycle 2 → no tag in cycle 4; a later LOAD 0x8 returns 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared bus types for the memory responder: command encoding, tag type and
// the completion pipeline entry.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef logic [3:0] MEM_TAG_T;

   localparam MEM_TAG_T EMPTY_MEM_TAG = 4'h0;

   typedef struct packed {
      logic        valid;
      MEM_TAG_T    tag;
      logic [63:0] data;
   } MEM_PIPE_ENTRY_T;

   localparam MEM_PIPE_ENTRY_T EMPTY_MEM_PIPE_ENTRY = '{valid: 1'b0, tag: EMPTY_MEM_TAG, data: 64'h0};

endpackage

// File: rtl/mem_responder_if.sv
// Processor/memory bus as seen by the memory responder: command side from the
// initiator, acceptance/completion side back from memory.
interface mem_responder_if
   import mem_responder_pkg::*;
#(
   parameter int NUM_TAGS = 15
);
   localparam int CNT_W = $clog2(NUM_TAGS + 1);

   BUS_COMMAND        proc2mem_command;
   logic [63:0]       proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic              accept_en;
   MEM_TAG_T          mem2proc_response;
   MEM_TAG_T          mem2proc_tag;
   logic [63:0]       mem2proc_data;
   logic [CNT_W-1:0]  tags_in_use;

   modport master (
      output proc2mem_command, proc2mem_addr, proc2mem_data, accept_en,
      input  mem2proc_response, mem2proc_tag, mem2proc_data, tags_in_use
   );

   modport slave (
      input  proc2mem_command, proc2mem_addr, proc2mem_data, accept_en,
      output mem2proc_response, mem2proc_tag, mem2proc_data, tags_in_use
   );

endinterface

// File: rtl/mem_responder_tag_free_list.sv
// Free list of memory tags 1..NUM_TAGS: offers the lowest free tag each cycle
// and tracks how many are allocated.
module tag_free_list
   import mem_responder_pkg::*;
#(
   parameter int NUM_TAGS = 15,
   parameter int CNT_W    = $clog2(NUM_TAGS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             alloc_en_i,
   input  logic             free_en_i,
   input  MEM_TAG_T         free_tag_i,
   output MEM_TAG_T         alloc_tag_o,
   output logic [CNT_W-1:0] in_use_o
);
   logic [NUM_TAGS-1:0] free_q, free_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                alloc_ok;

   // Scan downward so the lowest free index wins.
   always_comb begin
      alloc_tag_o = EMPTY_MEM_TAG;
      for (int i = NUM_TAGS - 1; i >= 0; i--)
         if (free_q[i]) alloc_tag_o = MEM_TAG_T'(i + 1);
   end

   assign alloc_ok = alloc_en_i && (alloc_tag_o != EMPTY_MEM_TAG);

   always_comb begin
      free_d = free_q;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (alloc_ok && alloc_tag_o == MEM_TAG_T'(i + 1)) free_d[i] = 1'b0;
         if (free_en_i && free_tag_i == MEM_TAG_T'(i + 1)) free_d[i] = 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(alloc_ok) - CNT_W'(free_en_i);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_q <= '1;
         cnt_q  <= '0;
      end else begin
         free_q <= free_d;
         cnt_q  <= cnt_d;
      end
   end

   assign in_use_o = cnt_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: same-cycle tag acceptance, fixed-latency in-order
// completion with load data, and a resettable 64-bit word array.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int NUM_TAGS  = 15,
   parameter int LATENCY   = 4,
   parameter int MEM_LINES = 256
) (
   input  logic           clock,
   input  logic           reset,
   mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_LINES);

   logic [63:0]     mem_q [MEM_LINES];
   MEM_PIPE_ENTRY_T pipe_q [LATENCY];
   MEM_PIPE_ENTRY_T pipe_d;
   logic [IDX_W-1:0] idx;
   MEM_TAG_T        free_tag;
   logic            req, accept;
   logic            unused_addr;

   assign idx         = bus.proc2mem_addr[3 +: IDX_W];
   assign unused_addr = ^{bus.proc2mem_addr[63:3+IDX_W], bus.proc2mem_addr[2:0]};

   assign req    = (bus.proc2mem_command != BUS_NONE) && bus.accept_en && !reset;
   assign accept = req && (free_tag != EMPTY_MEM_TAG);

   tag_free_list #(.NUM_TAGS(NUM_TAGS)) u_free (
      .clock       (clock),
      .reset       (reset),
      .alloc_en_i  (req),
      .free_en_i   (pipe_q[LATENCY-1].valid),
      .free_tag_i  (pipe_q[LATENCY-1].tag),
      .alloc_tag_o (free_tag),
      .in_use_o    (bus.tags_in_use)
   );

   assign bus.mem2proc_response = accept ? free_tag : EMPTY_MEM_TAG;

   // Load data is read before the edge; stores only land on the edge.
   always_comb begin
      pipe_d = EMPTY_MEM_PIPE_ENTRY;
      if (accept) begin
         pipe_d.valid = 1'b1;
         pipe_d.tag   = free_tag;
         pipe_d.data  = (bus.proc2mem_command == BUS_LOAD) ? mem_q[idx] : 64'h0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= EMPTY_MEM_PIPE_ENTRY;
      end else begin
         pipe_q[0] <= pipe_d;
         for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_LINES; i++) mem_q[i] <= 64'h0;
      end else if (accept && bus.proc2mem_command == BUS_STORE) begin
         mem_q[idx] <= bus.proc2mem_data;
      end
   end

   assign bus.mem2proc_tag  = pipe_q[LATENCY-1].tag;
   assign bus.mem2proc_data = pipe_q[LATENCY-1].data;

endmodule
